// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: one-hot T1..T6 ring plus opcode decode into the
// datapath strobes. Strobes settle after the rising edge; datapath samples on the falling edge.
module sap1_controller #(
  parameter int                 OPC_W  = 4,
  parameter logic [OPC_W-1:0]   OP_LDA = 4'b0000,
  parameter logic [OPC_W-1:0]   OP_ADD = 4'b0001,
  parameter logic [OPC_W-1:0]   OP_SUB = 4'b0010,
  parameter logic [OPC_W-1:0]   OP_OUT = 4'b1110,
  parameter logic [OPC_W-1:0]   OP_HLT = 4'b1111
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             step_en,
  input  logic [OPC_W-1:0] opcode,
  output logic [5:0]       t_state,
  output logic             Cp,
  output logic             Ep,
  output logic             Lm,
  output logic             CE,
  output logic             Li,
  output logic             Ei,
  output logic             La,
  output logic             Ea,
  output logic             Su,
  output logic             Eu,
  output logic             Lb,
  output logic             Lo,
  output logic             halted,
  output logic             instr_done
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  logic [5:0] state, state_nxt;
  logic       halted_nxt;
  logic       done_q, done_nxt;
  logic       run;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state  <= T1;
      halted <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
      done_q <= done_nxt;
    end
  end

  // HLT parks the ring at T4 instead of advancing; only CLR leaves that state.
  always_comb begin
    state_nxt  = state;
    halted_nxt = halted;
    done_nxt   = 1'b0;
    if (step_en && !halted) begin
      if (state == T4 && opcode == OP_HLT) begin
        halted_nxt = 1'b1;
      end else begin
        state_nxt = {state[4:0], state[5]};
        done_nxt  = state[5];
      end
    end
  end

  assign run        = step_en && !halted && !CLR;
  assign t_state    = state;
  assign instr_done = done_q && step_en;

  // Opcode is only consulted in T4..T6, so IR changes during fetch are invisible.
  always_comb begin
    Cp = 1'b0; Ep = 1'b0; Lm = 1'b0; CE = 1'b0; Li = 1'b0; Ei = 1'b0;
    La = 1'b0; Ea = 1'b0; Su = 1'b0; Eu = 1'b0; Lb = 1'b0; Lo = 1'b0;
    if (run) begin
      case (state)
        T1: begin Ep = 1'b1; Lm = 1'b1; end
        T2: Cp = 1'b1;
        T3: begin CE = 1'b1; Li = 1'b1; end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            Ei = 1'b1; Lm = 1'b1;
          end else if (opcode == OP_OUT) begin
            Ea = 1'b1; Lo = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            CE = 1'b1; La = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            CE = 1'b1; Lb = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            Eu = 1'b1; La = 1'b1; Su = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: cycle-level reference model feeding a scoreboard,
// plus a small falling-edge SAP-1 datapath for the program run.
module tb_sap1_controller;

  logic       CLK = 1'b0;
  logic       CLR, step_en, prog;
  logic [3:0] opcode, opcode_drv;
  logic [5:0] t_state;
  logic       Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, halted, instr_done;

  always #5 CLK = ~CLK;

  sap1_controller dut (
    .CLK(CLK), .CLR(CLR), .step_en(step_en), .opcode(opcode), .t_state(t_state),
    .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei), .La(La), .Ea(Ea),
    .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .halted(halted), .instr_done(instr_done)
  );

  // Datapath registers load on the falling edge from the strobes.
  logic [3:0] pc, mar;
  logic [7:0] ram [16];
  logic [7:0] ir, a, b, outr, bus;

  assign opcode = prog ? ir[7:4] : opcode_drv;

  always_comb begin
    bus = 8'h00;
    if (Ep)      bus = {4'h0, pc};
    else if (CE) bus = ram[mar];
    else if (Ei) bus = {4'h0, ir[3:0]};
    else if (Ea) bus = a;
    else if (Eu) bus = Su ? a - b : a + b;
  end

  always @(negedge CLK) begin
    if (CLR) pc <= 4'h0;
    else if (Cp) pc <= pc + 4'h1;
    if (Lm) mar  <= bus[3:0];
    if (Li) ir   <= bus;
    if (La) a    <= bus;
    if (Lb) b    <= bus;
    if (Lo) outr <= bus;
  end

  localparam logic [11:0] S_CP = 12'h800, S_EP = 12'h400, S_LM = 12'h200, S_CE = 12'h100;
  localparam logic [11:0] S_LI = 12'h080, S_EI = 12'h040, S_LA = 12'h020, S_EA = 12'h010;
  localparam logic [11:0] S_SU = 12'h008, S_EU = 12'h004, S_LB = 12'h002, S_LO = 12'h001;

  typedef struct packed {
    logic [5:0]  t;
    logic [11:0] s;
    logic        h;
    logic        d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   mt = 0;
  bit   mhalt = 1'b0;
  bit   mdone = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_strobes(input int t, input logic [3:0] op);
    logic [11:0] s;
    s = 12'h000;
    case (t)
      0: s = S_EP | S_LM;
      1: s = S_CP;
      2: s = S_CE | S_LI;
      3: if (op == 4'h0 || op == 4'h1 || op == 4'h2) s = S_EI | S_LM;
         else if (op == 4'hE) s = S_EA | S_LO;
      4: if (op == 4'h0) s = S_CE | S_LA;
         else if (op == 4'h1 || op == 4'h2) s = S_CE | S_LB;
      5: if (op == 4'h1) s = S_EU | S_LA;
         else if (op == 4'h2) s = S_EU | S_SU | S_LA;
      default: s = 12'h000;
    endcase
    return s;
  endfunction

  // One clock: drive at posedge+1, push expectation, compare at negedge, advance model at posedge.
  task automatic tick(input logic c, input logic s, input logic [3:0] op);
    exp_t e, got;
    logic [3:0] op_now;
    CLR = c; step_en = s; opcode_drv = op;
    #1;
    e.t = 6'b000001 << mt;
    e.s = (c || !s || mhalt) ? 12'h000 : exp_strobes(mt, opcode);
    e.h = mhalt;
    e.d = mdone && s;
    q.push_back(e);
    @(negedge CLK);
    got = q.pop_front();
    check("t_state", {26'h0, t_state}, {26'h0, got.t});
    check("strobes", {20'h0, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo}, {20'h0, got.s});
    check("halted", {31'h0, halted}, {31'h0, got.h});
    check("instr_done", {31'h0, instr_done}, {31'h0, got.d});
    check("onehot", {31'h0, $onehot(t_state)}, 32'h1);
    check("bus_rule", {31'h0, ($countones({Ep, CE, Ei, Ea, Eu}) <= 1)}, 32'h1);
    @(posedge CLK);
    op_now = opcode;
    if (c) begin
      mt = 0; mhalt = 1'b0; mdone = 1'b0;
    end else if (s && !mhalt) begin
      if (mt == 3 && op_now == 4'hF) begin
        mhalt = 1'b1; mdone = 1'b0;
      end else begin
        mdone = (mt == 5);
        mt = (mt + 1) % 6;
      end
    end else begin
      mdone = 1'b0;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0] = 8'h09; ram[1] = 8'h1A; ram[2] = 8'h2B; ram[3] = 8'hE0; ram[4] = 8'hF0;
    ram[9] = 8'd16; ram[10] = 8'd20; ram[11] = 8'd24;
    ir = 8'h00; mar = 4'h0; a = 8'h00; b = 8'h00; outr = 8'h00;
    prog = 1'b0; CLR = 1'b1; step_en = 1'b1; opcode_drv = 4'h0;
    @(posedge CLK); #1;

    // LDA fetch/execute, instr_done on the 7th cycle
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 4'h0);

    // SUB: Eu/Su/La together in T6 only
    tick(1'b1, 1'b1, 4'h2);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 4'h2);

    // Freeze at T2 for 5 clocks; PC must step exactly once
    tick(1'b1, 1'b1, 4'h0);
    tick(1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 4'h0);
    check("pc_frozen", {28'h0, pc}, 32'h0);
    tick(1'b0, 1'b1, 4'h0);
    check("pc_once", {28'h0, pc}, 32'h1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 4'h0);
    check("pc_after", {28'h0, pc}, 32'h1);

    // CLR at T5 of ADD aborts; CLR while halted restarts
    tick(1'b1, 1'b1, 4'h1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'h1);
    tick(1'b1, 1'b1, 4'h1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'h1);
    tick(1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 4'hF);
    tick(1'b0, 1'b0, 4'hF);
    tick(1'b1, 1'b0, 4'hF);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 4'h0);

    // Program: LDA 9, ADD A, SUB B, OUT, HLT
    prog = 1'b1;
    tick(1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 32; i++) tick(1'b0, 1'b1, 4'h0);
    check("prog_out", {24'h0, outr}, 32'd12);
    check("prog_halted", {31'h0, halted}, 32'h1);
    check("prog_pc", {28'h0, pc}, 32'd5);
    prog = 1'b0;

    // Random opcodes, step_en and CLR pulses
    tick(1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 300; i++)
      tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 4'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
